// File: rtl/mem_pkg.sv
// Shared definitions for the mem_responder backing-memory model: FSM states,
// default latency, stall-LFSR constants and the latency counter width helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int unsigned DEFAULT_LATENCY = 4;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 map to state bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Wide enough for LATENCY plus up to three injected stall cycles.
  function automatic int unsigned lat_cnt_width(input int unsigned lat);
    return $clog2(lat + 4);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, advancing every cycle; used for stall injection.
module lfsr8
  import mem_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [7:0] o_state
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/mem_responder.sv
// Word-granular memory responder with fixed request-to-response latency.
// Optional MEM_STALL_INJECT_EN adds 0-3 pseudo-random wait cycles per request.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_mem_ready,
  input  logic [31:0] i_mem_addr,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_valid,
  output logic        o_proto_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = lat_cnt_width(LATENCY);
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

  mem_state_t    r_state;
  mem_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_total;
  logic [1:0]    w_extra;
  logic          w_accept;
  logic          w_is_read;
  logic [AW-1:0] w_idx;
  logic          r_is_read;
  logic [31:0]   r_hold;
  logic [31:0]   r_rdata;
  logic          r_proto_err;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          w_unused;

  assign w_idx     = i_mem_addr[AW+1:2];
  assign w_accept  = (r_state == IDLE) && (i_mem_ren || i_mem_wen);
  assign w_is_read = i_mem_ren && !i_mem_wen;

`ifdef MEM_STALL_INJECT_EN
  logic [7:0] w_lfsr;

  lfsr8 u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_state (w_lfsr)
  );

  assign w_extra  = w_lfsr[1:0];
  assign w_unused = ^{i_mem_addr[31:AW+2], i_mem_addr[1:0], w_lfsr[7:2]};
`else
  assign w_extra  = '0;
  assign w_unused = ^{i_mem_addr[31:AW+2], i_mem_addr[1:0]};
`endif

  assign w_total = LAT_C + CW'(w_extra);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_total == CW'(1)) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = w_total - CW'(2);
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The word is captured at accept; the visible output only changes on entry
  // to RESP so it keeps the previous read value during the wait.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_read   <= 1'b0;
      r_hold      <= '0;
      r_rdata     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_read <= w_is_read;
        if (w_is_read) begin
          r_hold <= r_mem[w_idx];
        end
        if (i_mem_ren && i_mem_wen) begin
          r_proto_err <= 1'b1;
        end
      end
      if (w_accept && w_is_read && (w_state_nxt == RESP)) begin
        r_rdata <= r_mem[w_idx];
      end else if ((r_state == WAIT) && (w_state_nxt == RESP) && r_is_read) begin
        r_rdata <= r_hold;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept && i_mem_wen) begin
      r_mem[w_idx] <= i_mem_wdata;
    end
  end

  assign o_mem_ready = (r_state == IDLE);
  assign o_mem_valid = (r_state == RESP) && r_is_read;
  assign o_mem_rdata = r_rdata;
  assign o_proto_err = r_proto_err;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Word-granular backing-memory model that answers the cache's external memory interface. It is the responder to the cache's initiator: it accepts the cache's requests, applies a configurable response latency, and returns read data with a one-cycle valid pulse. It is used as the memory below each instruction cache and data cache in simulation and FPGA builds. Each accepted write is applied to the array. Every request is handled in order, one at a time.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2; AW = log2(DEPTH_WORDS).
LATENCY, 4, cycles from the request cycle (cycle 0) to the response cycle; minimum 1.

Ports:
i_clk  in  1  global clock
i_rst_n  in  1  asynchronous, active-low reset
o_mem_ready  out  1  high when a new request can be accepted
i_mem_addr  in  32  byte address; bits [1:0] ignored; word index = i_mem_addr[AW+1:2]
i_mem_ren  in  1  read request
i_mem_wen  in  1  write request
i_mem_wdata  in  32  write data; full word, no mask
o_mem_rdata  out  32  read data, valid while o_mem_valid is high, held afterwards
o_mem_valid  out  1  one-cycle pulse in the read response cycle
o_proto_err  out  1  sticky flag: i_mem_ren and i_mem_wen were seen together on an accepted request

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, o_mem_ready=1, o_mem_valid=0, o_mem_rdata=0, o_proto_err=0, counter=0.
  - Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- o_mem_ready = (state==IDLE), decoded combinationally from the state register.
- Accept: a request is accepted on the clock edge where state==IDLE and (i_mem_ren | i_mem_wen).
  - Address, operation and data are captured at that edge.
  - Requests while o_mem_ready=0 are ignored entirely.
- Write: the array is updated at the accept edge. The next request therefore reads the new value. No o_mem_valid pulse is produced for a write.
- Read: the array word is latched into the response register at the accept edge.
- Timing, with the request cycle counted as cycle 0:
  - o_mem_ready=0 in cycles 1..LATENCY.
  - For a read, o_mem_valid=1 only in cycle LATENCY (RESP state), and o_mem_rdata carries the word.
  - o_mem_ready returns to 1 in cycle LATENCY+1.
  - Throughput is therefore one request per LATENCY+1 cycles.
- Transitions:
  - IDLE -> RESP when LATENCY==1; otherwise IDLE -> WAIT with counter=LATENCY-2.
  - WAIT decrements the counter each cycle, and moves to RESP when the counter is 0.
  - RESP -> IDLE unconditionally.
  - Writes traverse the same states with o_mem_valid gated off.
- Counter width is clog2(LATENCY+4) bits, so stall injection cannot overflow it.
- Address wrap: upper address bits above AW+1 are ignored, so addresses alias modulo DEPTH_WORDS*4.
- Simultaneous i_mem_ren and i_mem_wen on an accept: treated as a write, and o_proto_err is set until reset.
- Reset mid-operation: o_mem_valid drops immediately and no pending response is issued. A write already accepted remains applied.
- o_mem_rdata holds its last read value until the next read response. Writes never alter it.

Optional Feature:
MEM_STALL_INJECT_EN
- Defined: an 8-bit Fibonacci LFSR is instantiated.
  - Taps 8,6,5,4; reset seed 8'hA5; advances every cycle.
  - On each accept, lfsr[1:0] extra WAIT cycles (0-3) are added to that request.
  - The response cycle becomes LATENCY+extra, and o_mem_ready returns one cycle later.
  - Used to stress the cache's busy handling.
- Undefined: the latency is exactly LATENCY and no LFSR logic exists.

Decomposition:
- Shared package (mem_pkg):
  - state encoding constants IDLE/WAIT/RESP
  - default LATENCY
  - LFSR seed 8'hA5 and tap mask
  - LATENCY width helper
- One sub-module, lfsr8: clock, reset and 8-bit state output. It is instantiated only under MEM_STALL_INJECT_EN.

Test Plan:
1. Reset: hold i_rst_n=0 mid-clock -> o_mem_ready=1, o_mem_valid=0, o_mem_rdata=0, o_proto_err=0 asynchronously.
2. LATENCY=4: write addr 0x0000_0010, data 0xDEADBEEF in cycle 0 -> o_mem_ready=0 in cycles 1-4, 1 in cycle 5, no valid. Then read 0x10 -> o_mem_valid=1 in its cycle 4 with o_mem_rdata=0xDEADBEEF, held after.
3. Line fill: reads 0x100, 0x104, 0x108, 0x10C, each issued when ready, after prior writes 1, 2, 3, 4 -> responses 1, 2, 3, 4 in order, each 5 cycles apart. A request held during not-ready is not double-accepted.
4. Alias (DEPTH_WORDS=1024): write 0x0000_1000 <- 0x12345678, read 0x0000_0000 -> 0x12345678. Read 0x0000_1002 (low bits set) -> same word.
5. i_mem_ren=1 and i_mem_wen=1 at 0x20 with 0xCAFEF00D -> no valid, o_proto_err=1 and sticky. A subsequent read of 0x20 returns 0xCAFEF00D.
6. Assert i_rst_n=0 in cycle 2 of a read -> no valid pulse ever. After release, o_mem_ready=1, and a new read completes normally with LATENCY timing.
